// File: rtl/countdown_timer.sv
// Down-counting mm:ss timer with a run/pause/expire state machine.
// Raises a one-cycle expiry pulse and a sticky alarm when the count reaches 00:00.
module countdown_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] status,
  output logic       expired,
  output logic       alarm
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RUNNING = 2'b01;
  localparam logic [1:0] PAUSED  = 2'b10;
  localparam logic [1:0] EXPIRED = 2'b11;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [5:0]    load_sec_clamped;
  logic          count_zero;
  logic          tick;
  logic          last_tick;

  assign load_sec_clamped = (load_sec > 6'd59) ? 6'd59 : load_sec;
  assign count_zero       = (minutes == 8'd0) && (seconds == 6'd0);
  assign tick             = (status == RUNNING) && (prescaler == PS_LAST);
  assign last_tick        = tick && (minutes == 8'd0) && (seconds == 6'd1);

  // A stop in RUNNING wins over a tick in the same cycle, so the shown count
  // and the partial second are both frozen at the moment of the stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      minutes   <= 8'd0;
      seconds   <= 6'd0;
      status    <= IDLE;
      expired   <= 1'b0;
      alarm     <= 1'b0;
      prescaler <= '0;
    end else begin
      expired <= 1'b0;
      if (clear) begin
        minutes   <= 8'd0;
        seconds   <= 6'd0;
        status    <= IDLE;
        alarm     <= 1'b0;
        prescaler <= '0;
      end else if (load) begin
        minutes   <= load_min;
        seconds   <= load_sec_clamped;
        status    <= IDLE;
        alarm     <= 1'b0;
        prescaler <= '0;
      end else if (stop && (status == RUNNING)) begin
        status <= PAUSED;
      end else if (tick) begin
        prescaler <= '0;
        if (seconds != 6'd0) begin
          seconds <= seconds - 6'd1;
        end else begin
          minutes <= minutes - 8'd1;
          seconds <= 6'd59;
        end
        if (last_tick) begin
          status  <= EXPIRED;
          expired <= 1'b1;
          alarm   <= 1'b1;
        end
      end else if (status == RUNNING) begin
        prescaler <= prescaler + 1'b1;
      end else if (start && !stop && !count_zero &&
                   ((status == IDLE) || (status == PAUSED))) begin
        status <= RUNNING;
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: table-driven vectors on a TICK_DIV=1
// instance plus hand-written prescaler sequences on a TICK_DIV=4 instance.
module tb_countdown_timer;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RUNNING = 2'b01;
  localparam logic [1:0] PAUSED  = 2'b10;
  localparam logic [1:0] EXPIRED = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'd0;
  logic [5:0] load_sec = 6'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;

  logic [7:0] minutes, minutes4;
  logic [5:0] seconds, seconds4;
  logic [1:0] status, status4;
  logic       expired, expired4;
  logic       alarm, alarm4;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         sel;
    logic       r, cl, ld, sp, st;
    logic [7:0] lmin;
    logic [5:0] lsec;
    logic [7:0] emin;
    logic [5:0] esec;
    logic [1:0] est;
    logic       eexp, ealm;
    string      name;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [17:0] val;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  countdown_timer #(.TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .stop(stop), .clear(clear),
    .minutes(minutes), .seconds(seconds), .status(status),
    .expired(expired), .alarm(alarm)
  );

  countdown_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .stop(stop), .clear(clear),
    .minutes(minutes4), .seconds(seconds4), .status(status4),
    .expired(expired4), .alarm(alarm4)
  );

  function automatic vec_t mk(bit sel, logic r, logic cl, logic ld, logic sp, logic st,
                              logic [7:0] lmin, logic [5:0] lsec,
                              logic [7:0] emin, logic [5:0] esec, logic [1:0] est,
                              logic eexp, logic ealm, string name);
    vec_t v;
    v.sel = sel; v.r = r; v.cl = cl; v.ld = ld; v.sp = sp; v.st = st;
    v.lmin = lmin; v.lsec = lsec;
    v.emin = emin; v.esec = esec; v.est = est; v.eexp = eexp; v.ealm = ealm;
    v.name = name;
    return v;
  endfunction

  task automatic check_output();
    exp_t        e;
    logic [17:0] act;
    e = sb.pop_front();
    act = e.sel ? {minutes4, seconds4, status4, expired4, alarm4}
                : {minutes, seconds, status, expired, alarm};
    total++;
    if (act !== e.val) begin
      bad++;
      $display("[TB] FAIL %s: got %0d:%0d st=%b exp=%b alm=%b, want %0d:%0d st=%b exp=%b alm=%b",
               e.name, act[17:10], act[9:4], act[3:2], act[1], act[0],
               e.val[17:10], e.val[9:4], e.val[3:2], e.val[1], e.val[0]);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.r; clear = v.cl; load = v.ld; stop = v.sp; start = v.st;
    load_min = v.lmin; load_sec = v.lsec;
    e.sel = v.sel;
    e.val = {v.emin, v.esec, v.est, v.eexp, v.ealm};
    e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  // Shorthands for the TICK_DIV=4 sequences: idle cycles and single strobes.
  task automatic idle4(input int n, input logic [7:0] m, input logic [5:0] s,
                       input logic [1:0] st, input logic ex, input logic al, input string name);
    for (int i = 0; i < n; i++)
      apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, m, s, st, ex, al, name));
  endtask

  task automatic run_tick4_sequences();
    apply_stimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0, "d4_clear"));
    apply_stimulus(mk(1, 0, 0, 1, 0, 0, 0, 2, 0, 2, IDLE, 0, 0, "d4_load_0002"));
    apply_stimulus(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 2, RUNNING, 0, 0, "d4_start"));
    idle4(3, 0, 2, RUNNING, 0, 0, "d4_prescale_hold");
    idle4(1, 0, 1, RUNNING, 0, 0, "d4_first_dec_at_4");
    idle4(3, 0, 1, RUNNING, 0, 0, "d4_prescale_hold2");
    idle4(1, 0, 0, EXPIRED, 1, 1, "d4_expire_at_8");
    idle4(1, 0, 0, EXPIRED, 0, 1, "d4_expired_one_cycle");
    apply_stimulus(mk(1, 0, 0, 1, 0, 0, 0, 5, 0, 5, IDLE, 0, 0, "d4_load_0005"));
    apply_stimulus(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 5, RUNNING, 0, 0, "d4_start2"));
    idle4(2, 0, 5, RUNNING, 0, 0, "d4_partial");
    apply_stimulus(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 5, PAUSED, 0, 0, "d4_stop"));
    idle4(5, 0, 5, PAUSED, 0, 0, "d4_paused_hold");
    apply_stimulus(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 5, RUNNING, 0, 0, "d4_resume"));
    idle4(1, 0, 5, RUNNING, 0, 0, "d4_resume_partial");
    idle4(1, 0, 4, RUNNING, 0, 0, "d4_dec_2_after_resume");
    idle4(3, 0, 4, RUNNING, 0, 0, "d4_full_second");
    idle4(1, 0, 3, RUNNING, 0, 0, "d4_next_dec");
  endtask

  initial begin
    // columns: sel r cl ld sp st lmin lsec | emin esec status expired alarm
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0, "reset"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5, 0, 5, IDLE, 0, 0, "load_0005"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5, RUNNING, 0, 0, "start_0005"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, RUNNING, 0, 0, "dec_04"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, RUNNING, 0, 0, "dec_03"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, RUNNING, 0, 0, "dec_02"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUNNING, 0, 0, "dec_01"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXPIRED, 1, 1, "expire_pulse"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXPIRED, 0, 1, "expire_hold"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, EXPIRED, 0, 1, "expired_ignore_start"));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, EXPIRED, 0, 1, "expired_ignore_stop"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0, "clear_drops_alarm"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, IDLE, 0, 0, "load_0100"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, RUNNING, 0, 0, "start_0100"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 59, RUNNING, 0, 0, "minute_borrow"));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 59, PAUSED, 0, 0, "stop_holds"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 59, PAUSED, 0, 0, "paused_1"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 59, PAUSED, 0, 0, "paused_2"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 59, PAUSED, 0, 0, "paused_3"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 59, RUNNING, 0, 0, "resume"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 58, RUNNING, 0, 0, "resume_dec"));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 58, PAUSED, 0, 0, "stop_again"));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 58, PAUSED, 0, 0, "start_stop_same"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 3, 3, 0, 0, IDLE, 0, 0, "load_clear_same"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 63, 0, 59, IDLE, 0, 0, "clamp_sec_63"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0, "clear_to_zero"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, IDLE, 0, 0, "start_at_zero"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 255, 59, 255, 59, IDLE, 0, 0, "load_max"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 255, 59, RUNNING, 0, 0, "start_max"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 255, 58, RUNNING, 0, 0, "dec_max"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 1, IDLE, 0, 0, "load_beats_start"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, RUNNING, 0, 0, "start_0001"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXPIRED, 1, 1, "expire_0001"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2, 0, 2, IDLE, 0, 0, "load_exits_expired"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 30, 0, 30, IDLE, 0, 0, "load_0030"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 30, RUNNING, 0, 0, "start_0030"));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 9, 9, 0, 0, IDLE, 0, 0, "rst_mid_run"));

    $display("[TB] starting countdown_timer checks");
    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i]);

    run_tick4_sequences();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
